// File: rtl/oled_power_sequencer.sv
// Power-up, reset and init sequencer for the Pmod OLEDrgb panel; afterwards forwards user bytes to the SPI byte master.
// Optional power-down path (pwr_off port, OFF_SEND/OFF_WAIT/PDN_WAIT) is built when OLED_PWRDN_EN is defined.
module oled_power_sequencer #(
  parameter int RST_WAIT_CYC = 300,
  parameter int RST_LOW_CYC  = 300,
  parameter int VCC_WAIT_CYC = 10000000,
  parameter int CNT_W        = 24
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       start,
  output logic       spi_start,
  output logic [7:0] spi_data,
  output logic       spi_dc,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic       usr_valid,
  input  logic [7:0] usr_data,
  input  logic       usr_dc,
  output logic       usr_ready,
  output logic       PMOD_EN,
  output logic       RES,
  output logic       VCC_EN,
  output logic       init_done,
  output logic [3:0] state
`ifdef OLED_PWRDN_EN
  ,
  input  logic       pwr_off
`endif
);

  typedef enum logic [3:0] {
    S_OFF      = 4'd0,
    S_PWR_WAIT = 4'd1,
    S_RES_LOW  = 4'd2,
    S_RES_WAIT = 4'd3,
    S_CMD_SEND = 4'd4,
    S_CMD_WAIT = 4'd5,
    S_VCC_WAIT = 4'd6,
    S_ON_SEND  = 4'd7,
    S_ON_WAIT  = 4'd8,
    S_READY    = 4'd9,
    S_USR_WAIT = 4'd10,
    S_OFF_SEND = 4'd11,
    S_OFF_WAIT = 4'd12,
    S_PDN_WAIT = 4'd13
  } state_t;

  // Wait states load N-1 on entry and leave on the cycle the counter reads zero, so each lasts N cycles.
  localparam logic [CNT_W-1:0] RST_WAIT_LD = CNT_W'(RST_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LOW_LD  = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] VCC_WAIT_LD = CNT_W'(VCC_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

  function automatic logic [7:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    init_rom = 8'hFD;
      2'd1:    init_rom = 8'h12;
      default: init_rom = 8'hAE;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       idx_r, idx_s;
  logic             pmod_en_r, pmod_en_s, res_r, res_s, vcc_en_r, vcc_en_s;
  logic             spi_start_r, spi_start_s, spi_dc_r, spi_dc_s;
  logic [7:0]       spi_data_r, spi_data_s;
  logic             usr_ready_r, usr_ready_s, init_done_r, init_done_s;
  logic             cnt_zero_s;

  assign cnt_zero_s = (cnt_r == CNT_ZERO);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    pmod_en_s   = pmod_en_r;
    res_s       = res_r;
    vcc_en_s    = vcc_en_r;
    spi_start_s = 1'b0;
    spi_data_s  = spi_data_r;
    spi_dc_s    = spi_dc_r;
    case (state_r)
      S_OFF: begin
        if (start) begin
          pmod_en_s = 1'b1;
          cnt_s     = RST_WAIT_LD;
          state_s   = S_PWR_WAIT;
        end else begin
          state_s = S_OFF;
        end
      end
      S_PWR_WAIT: begin
        if (cnt_zero_s) begin
          res_s   = 1'b0;
          cnt_s   = RST_LOW_LD;
          state_s = S_RES_LOW;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_RES_LOW: begin
        if (cnt_zero_s) begin
          res_s   = 1'b1;
          cnt_s   = RST_WAIT_LD;
          state_s = S_RES_WAIT;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_RES_WAIT: begin
        if (cnt_zero_s) begin
          idx_s   = 2'd0;
          state_s = S_CMD_SEND;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_CMD_SEND: begin
        if (spi_busy) begin
          state_s = S_CMD_SEND;
        end else begin
          spi_start_s = 1'b1;
          spi_data_s  = init_rom(idx_r);
          spi_dc_s    = 1'b0;
          state_s     = S_CMD_WAIT;
        end
      end
      S_CMD_WAIT: begin
        if (spi_done) begin
          if (idx_r == 2'd2) begin
            vcc_en_s = 1'b1;
            cnt_s    = VCC_WAIT_LD;
            state_s  = S_VCC_WAIT;
          end else begin
            idx_s   = idx_r + 2'd1;
            state_s = S_CMD_SEND;
          end
        end else begin
          state_s = S_CMD_WAIT;
        end
      end
      S_VCC_WAIT: begin
        if (cnt_zero_s) begin
          state_s = S_ON_SEND;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      S_ON_SEND: begin
        if (spi_busy) begin
          state_s = S_ON_SEND;
        end else begin
          spi_start_s = 1'b1;
          spi_data_s  = 8'hAF;
          spi_dc_s    = 1'b0;
          state_s     = S_ON_WAIT;
        end
      end
      S_ON_WAIT: begin
        if (spi_done) begin
          state_s = S_READY;
        end else begin
          state_s = S_ON_WAIT;
        end
      end
      S_READY: begin
`ifdef OLED_PWRDN_EN
        if (pwr_off) begin
          state_s = S_OFF_SEND;
        end else if (usr_valid && usr_ready_r) begin
`else
        if (usr_valid && usr_ready_r) begin
`endif
          spi_start_s = 1'b1;
          spi_data_s  = usr_data;
          spi_dc_s    = usr_dc;
          state_s     = S_USR_WAIT;
        end else begin
          state_s = S_READY;
        end
      end
      S_USR_WAIT: begin
        if (spi_done) begin
          state_s = S_READY;
        end else begin
          state_s = S_USR_WAIT;
        end
      end
`ifdef OLED_PWRDN_EN
      S_OFF_SEND: begin
        if (spi_busy) begin
          state_s = S_OFF_SEND;
        end else begin
          spi_start_s = 1'b1;
          spi_data_s  = 8'hAE;
          spi_dc_s    = 1'b0;
          state_s     = S_OFF_WAIT;
        end
      end
      S_OFF_WAIT: begin
        if (spi_done) begin
          vcc_en_s = 1'b0;
          cnt_s    = VCC_WAIT_LD;
          state_s  = S_PDN_WAIT;
        end else begin
          state_s = S_OFF_WAIT;
        end
      end
      S_PDN_WAIT: begin
        if (cnt_zero_s) begin
          pmod_en_s = 1'b0;
          res_s     = 1'b1;
          state_s   = S_OFF;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
`endif
      default: begin
        pmod_en_s = 1'b0;
        vcc_en_s  = 1'b0;
        res_s     = 1'b1;
        state_s   = S_OFF;
      end
    endcase
    usr_ready_s = (state_s == S_READY) && !spi_busy;
    init_done_s = (state_s == S_READY) || (state_s == S_USR_WAIT);
  end

  // State, counter and output registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_r     <= S_OFF;
      cnt_r       <= CNT_ZERO;
      idx_r       <= 2'd0;
      pmod_en_r   <= 1'b0;
      res_r       <= 1'b1;
      vcc_en_r    <= 1'b0;
      spi_start_r <= 1'b0;
      spi_data_r  <= 8'h00;
      spi_dc_r    <= 1'b0;
      usr_ready_r <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      pmod_en_r   <= pmod_en_s;
      res_r       <= res_s;
      vcc_en_r    <= vcc_en_s;
      spi_start_r <= spi_start_s;
      spi_data_r  <= spi_data_s;
      spi_dc_r    <= spi_dc_s;
      usr_ready_r <= usr_ready_s;
      init_done_r <= init_done_s;
    end
  end

  assign spi_start = spi_start_r;
  assign spi_data  = spi_data_r;
  assign spi_dc    = spi_dc_r;
  assign usr_ready = usr_ready_r;
  assign PMOD_EN   = pmod_en_r;
  assign RES       = res_r;
  assign VCC_EN    = vcc_en_r;
  assign init_done = init_done_r;
  assign state     = state_r;

endmodule

// File: tb/tb_oled_power_sequencer.sv
// Bench for oled_power_sequencer: SPI model (16 busy cycles then done) plus a byte scoreboard.
// Define OLED_PWRDN_EN for both files to exercise the power-down sequence as well.
module tb_oled_power_sequencer;
  logic       CLK = 1'b0;
  logic       rst, start, spi_start, spi_dc, spi_busy, spi_done;
  logic [7:0] spi_data, usr_data;
  logic       usr_valid, usr_dc, usr_ready, PMOD_EN, RES, VCC_EN, init_done;
  logic [3:0] state;
  logic       pwr_off;

  oled_power_sequencer #(
    .RST_WAIT_CYC(4), .RST_LOW_CYC(3), .VCC_WAIT_CYC(8), .CNT_W(24)
  ) dut (
    .CLK(CLK), .rst(rst), .start(start),
    .spi_start(spi_start), .spi_data(spi_data), .spi_dc(spi_dc),
    .spi_busy(spi_busy), .spi_done(spi_done),
    .usr_valid(usr_valid), .usr_data(usr_data), .usr_dc(usr_dc), .usr_ready(usr_ready),
    .PMOD_EN(PMOD_EN), .RES(RES), .VCC_EN(VCC_EN), .init_done(init_done), .state(state)
`ifdef OLED_PWRDN_EN
    , .pwr_off(pwr_off)
`endif
  );

  always #5 CLK = ~CLK;

  // SPI byte master model: busy for 16 cycles after a start, then a one-cycle done.
  logic       busy_m, done_m, busy_force;
  logic [4:0] bcnt;
  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      busy_m <= 1'b0; done_m <= 1'b0; bcnt <= 5'd0;
    end else begin
      done_m <= 1'b0;
      if (busy_m) begin
        if (bcnt == 5'd15) begin busy_m <= 1'b0; done_m <= 1'b1; end
        else bcnt <= bcnt + 5'd1;
      end else if (spi_start) begin
        busy_m <= 1'b1; bcnt <= 5'd0;
      end
    end
  end
  assign spi_busy = busy_m | busy_force;
  assign spi_done = done_m;

  int n_tests = 0, n_fail = 0;
  int start_cnt = 0, done_cnt = 0;
  logic [8:0] exp_q[$];  // {dc, data} in issue order
  logic prev_start = 1'b0;
  logic [8:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every spi_start is checked against the scoreboard and the busy/pulse rules.
  initial forever begin
    @(posedge CLK); #1;
    if (spi_done) done_cnt++;
    if (spi_start) begin
      start_cnt++;
      chk("start_while_busy", {31'd0, spi_busy}, 32'd0);
      chk("start_back_to_back", {31'd0, prev_start}, 32'd0);
      chk("start_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("spi_dc_data", {23'd0, spi_dc, spi_data}, {23'd0, e});
      end
    end
    prev_start = spi_start;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic wait_state(input logic [3:0] s, input int max, input string name);
    int k = 0;
    while (state !== s && k < max) begin @(negedge CLK); k++; end
    chk(name, {28'd0, state}, {28'd0, s});
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ctl"}, {25'd0, PMOD_EN, RES, VCC_EN, spi_start, spi_dc, usr_ready, init_done},
        {25'd0, 7'b0100000});
    chk({name, "_data"}, {24'd0, spi_data}, 32'd0);
    chk({name, "_state"}, {28'd0, state}, 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge CLK); start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [8:0] exp_byte;
  } vec_t;
  vec_t vecs[4];
  int k, s0, d0, first_low, low_n, ready_hi;

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 9'h15A};
    vecs[1] = '{8'hA5, 1'b0, 9'h0A5};
    vecs[2] = '{8'h00, 1'b1, 9'h100};
    vecs[3] = '{8'hFF, 1'b0, 9'h0FF};
    rst = 1'b1; start = 1'b0; usr_valid = 1'b0; usr_data = 8'h00; usr_dc = 1'b0;
    busy_force = 1'b0; pwr_off = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset("reset");
    rst = 1'b0;
    @(negedge CLK);
    chk("idle_without_start", {28'd0, state}, 32'd0);

    // Full power-up sequence.
    exp_q.push_back(9'h0FD); exp_q.push_back(9'h012);
    exp_q.push_back(9'h0AE); exp_q.push_back(9'h0AF);
    pulse_start();
    chk("pmod_en_after_start", {31'd0, PMOD_EN}, 32'd1);
    chk("pwr_wait_state", {28'd0, state}, 32'd1);
    first_low = -1; low_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (RES == 1'b0) begin
        low_n++;
        if (first_low < 0) first_low = i;
      end
      @(negedge CLK);
    end
    chk("res_low_offset", first_low, 32'd4);
    chk("res_low_len", low_n, 32'd3);
    chk("vcc_off_during_init", {31'd0, VCC_EN}, 32'd0);
    wait_state(4'd6, 400, "reach_vcc_wait");
    chk("vcc_en_on", {31'd0, VCC_EN}, 32'd1);
    chk("init_cmds_done", done_cnt, 32'd3);
    // VCC_WAIT lasts 8 cycles, ON_SEND one more, and spi_start is registered.
    k = 0;
    while (!spi_start && k < 30) begin @(negedge CLK); k++; end
    chk("af_delay", k, 32'd9);
    wait_state(4'd9, 100, "reach_ready");
    chk("init_done", {31'd0, init_done}, 32'd1);
    chk("on_cmd_done", done_cnt, 32'd4);
    chk("sb_empty_init", exp_q.size(), 32'd0);
    chk("usr_ready_in_ready", {31'd0, usr_ready}, 32'd1);

    // start while READY is ignored.
    pulse_start();
    @(negedge CLK);
    chk("start_in_ready", {26'd0, PMOD_EN, RES, VCC_EN, init_done, usr_ready, spi_start},
        {26'd0, 6'b111110});
    chk("start_in_ready_state", {28'd0, state}, 32'd9);

    // User transfers from the vector table; usr_valid is held for the whole transfer.
    for (int v = 0; v < 4; v++) begin
      k = 0;
      while (!usr_ready && k < 50) begin @(negedge CLK); k++; end
      chk("usr_ready_before", {31'd0, usr_ready}, 32'd1);
      exp_q.push_back(vecs[v].exp_byte);
      s0 = start_cnt; d0 = done_cnt;
      usr_valid = 1'b1; usr_data = vecs[v].data; usr_dc = vecs[v].dc;
      @(negedge CLK);
      ready_hi = 0; k = 0;
      while (done_cnt == d0 && k < 60) begin
        if (usr_ready) ready_hi++;
        @(negedge CLK); k++;
      end
      usr_valid = 1'b0;
      chk("usr_ready_low_during_xfer", ready_hi, 32'd0);
      chk("usr_single_start", start_cnt - s0, 32'd1);
      @(negedge CLK);
      chk("usr_ready_after_done", {31'd0, usr_ready}, 32'd1);
    end

    // Second run: start in RES_LOW ignored, then reset while waiting on byte 0x12.
    rst = 1'b1; @(negedge CLK); rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(9'h0FD); exp_q.push_back(9'h012);
    s0 = start_cnt;
    pulse_start();
    wait_state(4'd2, 20, "reach_res_low");
    pulse_start();
    chk("start_in_res_low", {27'd0, state, RES}, {27'd0, 4'd2, 1'b0});
    k = 0;
    while ((start_cnt < s0 + 2 || state != 4'd5) && k < 200) begin @(negedge CLK); k++; end
    chk("reach_cmd_wait_12", {28'd0, state}, 32'd5);
    repeat (3) @(negedge CLK);
    rst = 1'b1; #1;
    check_reset("async_reset");
    chk("sb_empty_run2", exp_q.size(), 32'd0);
    s0 = start_cnt;
    repeat (5) @(negedge CLK);
    chk("no_start_in_reset", start_cnt - s0, 32'd0);

    // Third run: external busy held through CMD_SEND.
    rst = 1'b0; busy_force = 1'b1;
    exp_q.push_back(9'h0FD); exp_q.push_back(9'h012);
    exp_q.push_back(9'h0AE); exp_q.push_back(9'h0AF);
    pulse_start();
    wait_state(4'd4, 30, "reach_cmd_send");
    s0 = start_cnt;
    repeat (10) @(negedge CLK);
    chk("held_in_cmd_send", {28'd0, state}, 32'd4);
    chk("no_start_while_busy", start_cnt - s0, 32'd0);
    busy_force = 1'b0;
    @(negedge CLK);
    chk("start_after_busy", start_cnt - s0, 32'd1);
    wait_state(4'd9, 400, "ready_after_busy");
    chk("run3_starts", start_cnt - s0, 32'd4);
    chk("sb_empty_run3", exp_q.size(), 32'd0);

`ifdef OLED_PWRDN_EN
    // Power-down wins over a simultaneous user byte.
    exp_q.push_back(9'h0AE);
    pwr_off = 1'b1; usr_valid = 1'b1; usr_data = 8'h33; usr_dc = 1'b1;
    @(negedge CLK);
    pwr_off = 1'b0; usr_valid = 1'b0;
    chk("off_send_state", {28'd0, state}, 32'd11);
    wait_state(4'd13, 100, "reach_pdn_wait");
    chk("vcc_en_off", {31'd0, VCC_EN}, 32'd0);
    chk("pmod_en_still_on", {31'd0, PMOD_EN}, 32'd1);
    k = 0;
    while (PMOD_EN && k < 30) begin @(negedge CLK); k++; end
    chk("pmod_off_delay", k, 32'd8);
    chk("pdn_final", {27'd0, state, init_done}, 32'd0);
    chk("pdn_res_high", {31'd0, RES}, 32'd1);
    chk("sb_empty_pdn", exp_q.size(), 32'd0);
`endif

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
